// File: rtl/wb_buffer.sv
// Writeback buffer: in-order FIFO between the ALU/FPU result mux and the register-file write port.
// Optional sticky FPU exception flag and saturating counter, enabled by defining WB_FFLAGS_EN.
module wb_buffer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_exception,
    input  logic            in_fpu_sel,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_wen_int,
    output logic            out_wen_fp,
    input  logic            fflags_clr,
    output logic            fflag_sticky,
    output logic [7:0]      exc_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0]  r_mem_result [DEPTH];
    logic [4:0]       r_mem_rd     [DEPTH];
    logic [DEPTH-1:0] r_mem_wen_int;
    logic [DEPTH-1:0] r_mem_wen_fp;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;
    logic w_wen_int;
    logic w_wen_fp;

    // Both handshake signals come from the registered count only, so there is
    // no combinational path from out_ready to in_ready.
    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Steering is resolved once at push time; x0 is hardwired, f0 is not.
    assign w_wen_int = in_wen && !in_fpu_sel && (in_rd != 5'd0);
    assign w_wen_fp  = in_wen && in_fpu_sel;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the entry storage is deliberately not reset; every output read from it
    // is gated by out_valid below, so stale contents can never reach the register file.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_result[r_wr_ptr]  <= in_result;
            r_mem_rd[r_wr_ptr]      <= in_rd;
            r_mem_wen_int[r_wr_ptr] <= w_wen_int;
            r_mem_wen_fp[r_wr_ptr]  <= w_wen_fp;
        end
    end

    assign out_result  = out_valid ? r_mem_result[r_rd_ptr] : '0;
    assign out_rd      = out_valid ? r_mem_rd[r_rd_ptr]     : 5'd0;
    assign out_wen_int = out_valid && r_mem_wen_int[r_rd_ptr];
    assign out_wen_fp  = out_valid && r_mem_wen_fp[r_rd_ptr];

`ifdef WB_FFLAGS_EN
    logic       r_fflag_sticky;
    logic [7:0] r_exc_count;
    logic       w_exc_event;

    // ALU entries never raise exceptions, whatever in_exception says.
    assign w_exc_event = w_push && in_fpu_sel && in_exception;

    // A same-cycle exception beats a clear: the event becomes the first one counted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fflag_sticky <= 1'b0;
            r_exc_count    <= 8'd0;
        end else if (w_exc_event) begin
            r_fflag_sticky <= 1'b1;
            if (fflags_clr)
                r_exc_count <= 8'd1;
            else if (r_exc_count != 8'hFF)
                r_exc_count <= r_exc_count + 8'd1;
        end else if (fflags_clr) begin
            r_fflag_sticky <= 1'b0;
            r_exc_count    <= 8'd0;
        end
    end

    assign fflag_sticky = r_fflag_sticky;
    assign exc_count    = r_exc_count;
`else
    logic w_unused_flags;
    assign w_unused_flags = fflags_clr ^ in_exception;
    assign fflag_sticky   = 1'b0;
    assign exc_count      = 8'd0;
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Scoreboard bench for wb_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model (flag model follows WB_FFLAGS_EN).
module tb_wb_buffer;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
`ifdef WB_FFLAGS_EN
    localparam logic FF_EN = 1'b1;
`else
    localparam logic FF_EN = 1'b0;
`endif

    logic            CLK;
    logic            RST_N;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_result;
    logic            in_exception;
    logic            in_fpu_sel;
    logic [4:0]      in_rd;
    logic            in_wen;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_wen_int;
    logic            out_wen_fp;
    logic            fflags_clr;
    logic            fflag_sticky;
    logic [7:0]      exc_count;

    wb_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_exception (in_exception),
        .in_fpu_sel   (in_fpu_sel),
        .in_rd        (in_rd),
        .in_wen       (in_wen),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wen_int  (out_wen_int),
        .out_wen_fp   (out_wen_fp),
        .fflags_clr   (fflags_clr),
        .fflag_sticky (fflag_sticky),
        .exc_count    (exc_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            wen_int;
        logic            wen_fp;
    } exp_t;

    exp_t exp_q[$];
    logic exp_sticky;
    int   exp_cnt;
    int   checks;
    int   failures;
    bit   rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: the buffer is an ordered list of pending writes,
    // and the flags are a sticky bit plus a count clipped at 255.
    always @(negedge CLK) begin
        if (!RST_N) begin
            exp_q.delete();
            exp_sticky = 1'b0;
            exp_cnt    = 0;
        end else begin
            bit   accept;
            exp_t e;
            accept = in_valid && (exp_q.size() != DEPTH);
            check("out_valid", out_valid, exp_q.size() != 0);
            check("in_ready", in_ready, exp_q.size() != DEPTH);
            check("fflag_sticky", fflag_sticky, exp_sticky);
            check("exc_count", exc_count, exp_cnt);
            if (exp_q.size() != 0) begin
                check("out_result", out_result, exp_q[0].result);
                check("out_rd", out_rd, exp_q[0].rd);
                check("out_wen_int", out_wen_int, exp_q[0].wen_int);
                check("out_wen_fp", out_wen_fp, exp_q[0].wen_fp);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (accept) begin
                e.result  = in_result;
                e.rd      = in_rd;
                e.wen_int = in_wen && !in_fpu_sel && (in_rd != 0);
                e.wen_fp  = in_wen && in_fpu_sel;
                exp_q.push_back(e);
            end
            if (FF_EN) begin
                if (accept && in_fpu_sel && in_exception) begin
                    exp_sticky = 1'b1;
                    exp_cnt    = fflags_clr ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
                end else if (fflags_clr) begin
                    exp_sticky = 1'b0;
                    exp_cnt    = 0;
                end
            end
        end
    end

    // Present one result and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic push(input logic [31:0] res, input logic exc, input logic fsel,
                        input logic [4:0] rd, input logic wen);
        int n;
        in_valid     = 1'b1;
        in_result    = res;
        in_exception = exc;
        in_fpu_sel   = fsel;
        in_rd        = rd;
        in_wen       = wen;
        n = 0;
        @(negedge CLK);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL push_timeout in_ready stuck at 0, expected 1 within 200 cycles");
                in_valid = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int cycles);
        in_valid   = 1'b0;
        fflags_clr = 1'b0;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; rand_done = 1'b0;
        exp_sticky = 1'b0; exp_cnt = 0;
        RST_N = 1'b0; in_valid = 1'b0; in_result = '0; in_exception = 1'b0;
        in_fpu_sel = 1'b0; in_rd = '0; in_wen = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_wen", {out_wen_int, out_wen_fp}, 0);
        check("rst_flags", {fflag_sticky, exc_count}, 0);
        RST_N = 1'b1;
        idle(2);

        // Single ALU push, visible the cycle after acceptance, then drained.
        out_ready = 1'b1;
        push(32'h0000_002A, 1'b0, 1'b0, 5'd5, 1'b1);
        check("lat_out_valid", out_valid, 1);
        check("lat_out_result", out_result, 32'h2A);
        check("lat_out_rd", out_rd, 5);
        check("lat_wen", {out_wen_int, out_wen_fp}, 2'b10);
        idle(1);
        check("lat_drained", out_valid, 0);

        // Backpressure: two fill the buffer, the third waits until out_ready rises.
        out_ready = 1'b0;
        push(32'h1111_0001, 1'b0, 1'b0, 5'd1, 1'b1);
        push(32'h2222_0002, 1'b0, 1'b1, 5'd2, 1'b1);
        check("full_in_ready", in_ready, 0);
        fork
            push(32'h3333_0003, 1'b0, 1'b0, 5'd3, 1'b1);
            begin
                repeat (3) @(posedge CLK);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);
        check("bp_drained", out_valid, 0);

        // x0 suppression for ALU writes; f0 stays writable.
        out_ready = 1'b0;
        push(32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 1'b1);
        check("x0_wen", {out_wen_int, out_wen_fp}, 2'b00);
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        push(32'hCAFE_F00D, 1'b0, 1'b1, 5'd0, 1'b1);
        check("f0_wen", {out_wen_int, out_wen_fp}, 2'b01);
        out_ready = 1'b1;
        idle(2);

        // FPU exception counts; ALU exception bit is ignored.
        push(32'h0000_0010, 1'b1, 1'b1, 5'd7, 1'b1);
        push(32'h0000_0020, 1'b1, 1'b0, 5'd8, 1'b1);
        idle(2);
        check("exc_sticky", fflag_sticky, FF_EN);
        check("exc_one", exc_count, FF_EN ? 1 : 0);

        // Saturation, then clear racing an exception, then a plain clear.
        for (int i = 0; i < 300; i++)
            push($urandom, 1'b1, 1'b1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        idle(2);
        check("exc_saturate", exc_count, FF_EN ? 255 : 0);
        fflags_clr = 1'b1;
        push(32'h0000_0BAD, 1'b1, 1'b1, 5'd9, 1'b1);
        idle(2);
        check("clr_race_sticky", fflag_sticky, FF_EN);
        check("clr_race_count", exc_count, FF_EN ? 1 : 0);
        fflags_clr = 1'b1;
        @(posedge CLK);
        #1 fflags_clr = 1'b0;
        check("clr_sticky", fflag_sticky, 0);
        check("clr_count", exc_count, 0);

        // Randomized traffic with random backpressure and occasional clears.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        idle(1);
                    end else begin
                        fflags_clr = ($urandom_range(0, 7) == 0);
                        push($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                             1'($urandom_range(0, 3) != 0));
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge CLK);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        idle(4);
        check("rand_drained", out_valid, 0);

        // Asynchronous reset with a full buffer: entries are discarded.
        out_ready = 1'b0;
        push(32'hAAAA_0001, 1'b1, 1'b1, 5'd11, 1'b1);
        push(32'hAAAA_0002, 1'b0, 1'b0, 5'd12, 1'b1);
        idle(0);
        #2 RST_N = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_outputs", {out_wen_int, out_wen_fp, out_rd}, 0);
        check("arst_flags", {fflag_sticky, exc_count}, 0);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        out_ready = 1'b1;
        idle(4);
        check("arst_no_stale", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
